// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: instruction width, PC increment, fetch state enum, PC alignment helper.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  // FAULT is only ever entered when INSTR_FETCH_ALIGN_CHECK_EN is defined.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DONE  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // Drops the byte offset so a target always lands on a word boundary.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register holding one fetched instruction and its PC.
// Latency: 1 cycle from load to out_vld.
// Backpressure: contents held while out_vld && !out_rdy; clear wins over load.
// Ports: clk, reset (sync, active-high), load/clear controls, in_instr/in_pc
//        data in, out_vld/out_rdy handshake, out_instr/out_pc registered data.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [31:0]        in_pc,
  input  logic               out_rdy,
  output logic               out_vld,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc
);

  logic               vld_d,   vld_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [31:0]        pc_d,    pc_q;

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    // A transfer in the same cycle as clear still completes; decode took it.
    if (vld_q && out_rdy) vld_d = 1'b0;
    if (load) begin
      vld_d   = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
    if (clear) vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_vld   = vld_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses a combinational imem, registers the result for decode.
// Latency: 1 cycle from imem_addr to if_valid; redirect costs one bubble.
// Backpressure: if_ready low holds PC and output register; fetch stops at PC_LIMIT.
// Ports: clk/reset (sync, active-high); imem_addr/imem_instr memory side;
//        redirect_valid/redirect_pc control flow; if_valid/if_ready/if_instr/if_pc
//        to decode; fetch_done status; fetch_fault only with INSTR_FETCH_ALIGN_CHECK_EN,
//        which turns a misaligned redirect into a sticky FAULT state.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd40
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic               fetch_done
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  ,
  output logic               fetch_fault
`endif
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic         done_d, done_q;
  logic         slot_free;
  logic         load, clear;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  logic         fault_d, fault_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    done_d    = done_q;
    load      = 1'b0;
    clear     = 1'b0;
    slot_free = !if_valid || if_ready;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    if (redirect_valid && (state_q != ST_FAULT)) begin
      // The instruction on imem_instr this cycle belongs to the old path.
      clear  = 1'b1;
      done_d = 1'b0;
      state_d = ST_RUN;
      pc_d    = pc_align(redirect_pc);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
        pc_d    = redirect_pc;
      end
`endif
    end else if (state_q == ST_RUN) begin
      if (pc_q >= PC_LIMIT) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else if (slot_free) begin
        load = 1'b1;
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      done_q  <= 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  fetch_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .clear     (clear),
    .in_instr  (imem_instr),
    .in_pc     (pc_q),
    .out_rdy   (if_ready),
    .out_vld   (if_valid),
    .out_instr (if_instr),
    .out_pc    (if_pc)
  );

  assign imem_addr  = pc_q;
  assign fetch_done = done_q;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] LIM = 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_done;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_instr = mem(imem_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000), .PC_LIMIT(LIM)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_done     (fetch_done)
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  // Behavioural model: fetch_mode 0 = fetching, 1 = finished, 2 = faulted.
  logic [31:0] m_pc, m_pcout, m_instr;
  logic        m_vld, m_done, m_fault;
  int          m_mode;

  task automatic model_step();
    logic misaligned;
    misaligned = 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    misaligned = (redirect_pc % 4) != 0;
`endif
    if (reset) begin
      m_pc = 0; m_vld = 0; m_pcout = 0; m_instr = 0;
      m_done = 0; m_fault = 0; m_mode = 0;
    end else if (redirect_valid && m_mode != 2) begin
      m_vld  = 0;
      m_done = 0;
      if (misaligned) begin
        m_mode = 2; m_fault = 1; m_pc = redirect_pc;
      end else begin
        m_mode = 0; m_pc = redirect_pc - (redirect_pc % 4);
      end
    end else begin
      if (m_vld && if_ready) m_vld = 0;
      if (m_mode == 0) begin
        if (m_pc >= LIM) begin
          m_mode = 1; m_done = 1;
        end else if (!m_vld) begin
          m_vld = 1; m_pcout = m_pc; m_instr = mem(m_pc); m_pc = m_pc + 4;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
    reset = r; redirect_valid = rv; redirect_pc = rp; if_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_valid"}, 32'(if_valid), 32'(m_vld));
    chk({tag, "_addr"}, imem_addr, m_pc);
    chk({tag, "_done"}, 32'(fetch_done), 32'(m_done));
    if (m_vld) begin
      chk({tag, "_pc"}, if_pc, m_pcout);
      chk({tag, "_instr"}, if_instr, m_instr);
    end
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    chk({tag, "_fault"}, 32'(fetch_fault), 32'(m_fault));
`endif
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        edone;
  } vec_t;

  vec_t tbl[13];
  logic [31:0] acc[$];

  initial begin
    @(negedge clk);
    // Cycle-by-cycle table from reset release: run, redirect, stall into DONE,
    // redirect out of DONE, redirect past the limit.
    tbl[0]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 32'h00, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0, 32'h04, 1'b0};
    tbl[2]  = '{1'b1, 32'h4,  1'b1, 1'b1, 32'h4, 32'h08, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 32'h04, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h4, 32'h08, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h8, 32'h0C, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h8, 32'h0C, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h8, 32'h0C, 1'b1};
    tbl[8]  = '{1'b1, 32'h0,  1'b1, 1'b0, 32'h0, 32'h0C, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 32'h00, 1'b0};
    tbl[10] = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h0, 32'h04, 1'b0};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 32'h20, 1'b0};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 32'h20, 1'b1};

    do_reset();
    chk("reset_if_pc", if_pc, 32'h0);
    chk("reset_if_instr", if_instr, 32'h0);
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_done", i), 32'(fetch_done), 32'(tbl[i].edone));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), if_instr, mem(tbl[i].epc));
      end
      tick();
    end

    // Straight run to the limit with decode always ready.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (c >= 1 && c <= 3) begin
        chk($sformatf("run_c%0d_valid", c), 32'(if_valid), 32'd1);
        chk($sformatf("run_c%0d_pc", c), if_pc, 32'((c - 1) * 4));
      end
      if (c >= 4) begin
        chk($sformatf("run_c%0d_done", c), 32'(fetch_done), 32'd1);
        chk($sformatf("run_c%0d_valid", c), 32'(if_valid), 32'd0);
      end
      tick();
    end

    // Stall in cycles 2-4: output held, nothing lost or duplicated.
    do_reset();
    acc.delete();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 32'h0, !(c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) begin
        chk($sformatf("stall_c%0d_pc", c), if_pc, 32'h4);
        chk($sformatf("stall_c%0d_instr", c), if_instr, mem(32'h4));
        chk($sformatf("stall_c%0d_addr", c), imem_addr, 32'h8);
      end
      if (if_valid && if_ready) acc.push_back(if_pc);
      tick();
    end
    chk("stall_count", 32'(acc.size()), 32'd3);
    for (int k = 0; k < acc.size() && k < 3; k++)
      chk($sformatf("stall_seq%0d", k), acc[k], 32'(k * 4));

    // Reset overrides a pending instruction and a redirect.
    do_reset();
    tick(); tick();
    drive(1'b1, 1'b1, 32'h8, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_ovr_valid", 32'(if_valid), 32'd0);
    chk("rst_ovr_pc", if_pc, 32'h0);
    chk("rst_ovr_instr", if_instr, 32'h0);
    chk("rst_ovr_done", 32'(fetch_done), 32'd0);
    chk("rst_ovr_addr", imem_addr, 32'h0);

    // Misaligned redirect to 0x06.
    do_reset();
    tick();
    drive(1'b0, 1'b1, 32'h6, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_valid", 32'(if_valid), 32'd0);
    drive(1'b0, 1'b1, 32'h0, 1'b1);
    tick(); tick();
    chk("mis_sticky_fault", 32'(fetch_fault), 32'd1);
    chk("mis_sticky_valid", 32'(if_valid), 32'd0);
    chk("mis_sticky_addr", imem_addr, 32'h6);
    do_reset();
    chk("mis_reset_fault", 32'(fetch_fault), 32'd0);
`else
    chk("mis_addr", imem_addr, 32'h4);
    chk("mis_valid", 32'(if_valid), 32'd0);
    tick();
    chk("mis_next_valid", 32'(if_valid), 32'd1);
    chk("mis_next_pc", if_pc, 32'h4);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r, rv, rd;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 9) < 7);
      rp = 32'($urandom_range(0, 5) * 4);
      if ($urandom_range(0, 7) == 0) rp = rp + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) rp = 32'hFFFF_FFFC;
      compare_model($sformatf("rnd%0d", c));
      drive(r, rv, rp, rd);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
